// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle for bin2bcd_seq.
// BIN2BCD_BLANK_EN adds the registered leading-zero blanking vector.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      x;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, x,
    input  busy, done, bcd, overflow, blank
  );

  modport slave (
    input  start, x,
    output busy, done, bcd, overflow, blank
  );
`else
  modport master (
    output start, x,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, x,
    output busy, done, bcd, overflow
  );
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional BIN2BCD_BLANK_EN adds a leading-zero blanking output on the interface.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 2 || WIDTH > 32 || DIGITS < 1 || DIGITS > 10) begin : g_param_check
      $error("bin2bcd_seq: WIDTH must be 2..32 and DIGITS 1..10");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             overflow_q, overflow_d;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    acc_sh;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_nx;
  logic              zero_run;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q    <= ~DIGITS'(1);
`endif
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;

    // Per-digit add-3 with no inter-digit carry, then shift in the next binary MSB.
    adj = acc_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    acc_sh = {adj[BW-2:0], bin_q[WIDTH-1]};

`ifdef BIN2BCD_BLANK_EN
    blank_d  = blank_q;
    blank_nx = '0;
    zero_run = 1'b1;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run & (acc_sh[4*k +: 4] == 4'd0);
      blank_nx[k] = zero_run;
    end
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          bin_d   = bus.x;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bin_d = bin_q << 1;
        acc_d = acc_sh;
        ovf_d = ovf_q | adj[BW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          bcd_d      = acc_sh;
          overflow_d = ovf_q | adj[BW-1];
`ifdef BIN2BCD_BLANK_EN
          blank_d    = blank_nx;
`endif
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;
`ifdef BIN2BCD_BLANK_EN
  assign bus.blank    = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed steps plus random samples,
// with a decimal reference model feeding per-instance scoreboards.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) b1 ();
  bin2bcd_seq_if #(.WIDTH(12), .DIGITS(3)) b2 ();

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  bin2bcd_seq #(.WIDTH(12), .DIGITS(3)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct packed {
    logic [39:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks   = 0;
  int   failures = 0;
  logic d1_prev  = 1'b0;
  logic d2_prev  = 1'b0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned v, input int digits);
    exp_t e;
    e.bcd = '0;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    e.ovf = (v != 0);
    return e;
  endfunction

`ifdef BIN2BCD_BLANK_EN
  function automatic logic [39:0] blank_model(input logic [39:0] b, input int digits);
    logic [39:0] r;
    logic        z;
    r = '0;
    z = 1'b1;
    for (int k = digits - 1; k >= 1; k--) begin
      z    = z & (b[4*k +: 4] == 4'd0);
      r[k] = z;
    end
    return r;
  endfunction
`endif

  // Scoreboard monitors: pop one expectation per done pulse.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      d1_prev <= 1'b0;
    end else begin
      if (b1.done === 1'b1) begin
        chk("dut1_done_single", 40'(d1_prev), 40'h0);
        chk("dut1_busy_in_done", 40'(b1.busy), 40'h0);
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL dut1_spurious_done observed=done expected=no_done");
        end else begin
          e = q1.pop_front();
          chk("dut1_bcd", 40'(b1.bcd), e.bcd);
          chk("dut1_ovf", 40'(b1.overflow), 40'(e.ovf));
`ifdef BIN2BCD_BLANK_EN
          chk("dut1_blank", 40'(b1.blank), blank_model(e.bcd, 5));
`endif
        end
      end
      d1_prev <= b1.done;
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst) begin
      d2_prev <= 1'b0;
    end else begin
      if (b2.done === 1'b1) begin
        chk("dut2_done_single", 40'(d2_prev), 40'h0);
        if (q2.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL dut2_spurious_done observed=done expected=no_done");
        end else begin
          e = q2.pop_front();
          chk("dut2_bcd", 40'(b2.bcd), e.bcd);
          chk("dut2_ovf", 40'(b2.overflow), 40'(e.ovf));
`ifdef BIN2BCD_BLANK_EN
          chk("dut2_blank", 40'(b2.blank), blank_model(e.bcd, 3));
`endif
        end
      end
      d2_prev <= b2.done;
    end
  end

  task automatic go1(input logic [15:0] v);
    b1.start = 1'b1;
    b1.x     = v;
    q1.push_back(model(32'(v), 5));
    @(posedge clk);
    #1;
    b1.start = 1'b0;
  endtask

  task automatic go2(input logic [11:0] v);
    b2.start = 1'b1;
    b2.x     = v;
    q2.push_back(model(32'(v), 3));
    @(posedge clk);
    #1;
    b2.start = 1'b0;
  endtask

  // Negedges from the accepting edge until done; bounded.
  task automatic wait_done1(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b1.done !== 1'b1 && n < 40);
  endtask

  task automatic wait_done2(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b2.done !== 1'b1 && n < 40);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int   n;
    int   busy_n;
    logic any_done;
    logic [15:0] rv;

    rst      = 1'b1;
    b1.start = 1'b0;
    b1.x     = '0;
    b2.start = 1'b0;
    b2.x     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 40'(b1.busy), 40'h0);
    chk("rst_done", 40'(b1.done), 40'h0);
    chk("rst_bcd", 40'(b1.bcd), 40'h0);
    chk("rst_ovf", 40'(b1.overflow), 40'h0);
`ifdef BIN2BCD_BLANK_EN
    chk("rst_blank", 40'(b1.blank), 40'b11110);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-scale value, with a stray start pulse mid-conversion.
    go1(16'hFFFF);
    b1.x   = 16'h1111;
    n      = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (b1.busy === 1'b1) busy_n++;
      if (n == 5) begin
        b1.start = 1'b1;
        b1.x     = 16'h0000;
      end
      if (n == 6) begin
        b1.start = 1'b0;
        b1.x     = 16'h0BAD;
      end
    end while (b1.done !== 1'b1 && n < 40);
    chk("ffff_latency", 40'(n), 40'd17);
    chk("ffff_busy_cycles", 40'(busy_n), 40'd16);
    @(negedge clk);
    chk("ffff_hold_bcd", 40'(b1.bcd), 40'h65535);
    chk("ffff_done_low", 40'(b1.done), 40'h0);
    chk("ffff_idle_busy", 40'(b1.busy), 40'h0);

    // Zero input.
    @(posedge clk);
    #1;
    go1(16'd0);
    wait_done1(n);
    chk("zero_latency", 40'(n), 40'd17);

    // Narrow instance: in range, boundary and overflow.
    go2(12'd999);
    wait_done2(n);
    chk("w12_latency", 40'(n), 40'd13);
    go2(12'd4095);
    wait_done2(n);
    go2(12'd1000);
    wait_done2(n);
    go2(12'd0);
    wait_done2(n);

    // Back-to-back with start held high; x changes mid-conversion.
    @(posedge clk);
    #1;
    b1.start = 1'b1;
    b1.x     = 16'd1234;
    q1.push_back(model(32'd1234, 5));
    q1.push_back(model(32'd4321, 5));
    @(posedge clk);
    #1;
    b1.x = 16'd4321;
    wait_done1(n);
    chk("b2b_first_latency", 40'(n), 40'd17);
    @(posedge clk);
    #1;
    b1.start = 1'b0;
    b1.x     = 16'hFFFF;
    wait_done1(n);
    chk("b2b_spacing", 40'(n), 40'd17);

    // Reset in the middle of a conversion.
    @(posedge clk);
    #1;
    go1(16'd9999);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(q1.pop_back());
    @(negedge clk);
    chk("abort_busy", 40'(b1.busy), 40'h0);
    chk("abort_bcd", 40'(b1.bcd), 40'h0);
    chk("abort_ovf", 40'(b1.overflow), 40'h0);
`ifdef BIN2BCD_BLANK_EN
    chk("abort_blank", 40'(b1.blank), 40'b11110);
`endif
    @(posedge clk);
    #1;
    rst      = 1'b0;
    any_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (b1.done === 1'b1) any_done = 1'b1;
    end
    chk("abort_no_done", 40'(any_done), 40'h0);
    @(posedge clk);
    #1;
    go1(16'd42);
    wait_done1(n);
    chk("after_abort_latency", 40'(n), 40'd17);
    chk("after_abort_bcd", 40'(b1.bcd), 40'h00042);

    // Random samples, back-to-back, with x disturbed while busy.
    for (int i = 0; i < 1000; i++) begin
      rv = 16'($urandom_range(0, 65535));
      go1(rv);
      b1.x = 16'($urandom);
      wait_done1(n);
      if (n != 17) chk("rand_latency", 40'(n), 40'd17);
    end

    for (int i = 0; i < 100; i++) begin
      go2(12'($urandom_range(0, 4095)));
      b2.x = 12'($urandom);
      wait_done2(n);
      if (n != 13) chk("rand_w12_latency", 40'(n), 40'd13);
    end

    @(negedge clk);
    chk("q1_drained", 40'(q1.size()), 40'h0);
    chk("q2_drained", 40'(q2.size()), 40'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
